// File: rtl/key_pkg.sv
// ============================================================================
//  Module      : key_pkg
//  Description : Shared types and constants for the key event classifier.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package key_pkg;

  // Classifier states; the width is fixed at 2 bits.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS1   = 2'd1,
    WAIT2    = 2'd2,
    WAIT_REL = 2'd3
  } key_state_t;

  // The key is active-low: a 0 on the debounced level means pressed.
  localparam logic KEY_PRESSED = 1'b0;

  // Number of sysclk cycles in one 1 ms tick for a given clock period in ns.
  function automatic int tick_cyc_default(input int clk_cyc_ns);
    return 1_000_000 / clk_cyc_ns;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_event_ms_tick.sv
// ============================================================================
//  Module      : ms_tick
//  Description : 1 ms timebase prescaler with synchronous clear. The tick
//                output is high during the last cycle of each period.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ms_tick #(
  parameter int TICK_CYC = 100_000
) (
  input  logic sysclk,
  input  logic sysrst,
  input  logic clr,
  output logic tick
);

  localparam int              PW     = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [PW-1:0]   C_LAST = PW'(TICK_CYC - 1);
  localparam logic [PW-1:0]   C_ONE  = PW'(1);

  logic [PW-1:0] r_presc;

  assign tick = (r_presc == C_LAST);

  // Prescaler: counts 0..TICK_CYC-1, restarts on wrap or on clear.
  always_ff @(posedge sysclk) begin
    if (sysrst || clr) begin
      r_presc <= '0;
    end else if (tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + C_ONE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/key_event.sv
// ============================================================================
//  Module      : key_event
//  Description : Turns a debounced, active-low key level into one-cycle
//                short-press, double-click and long-press pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_event
  import key_pkg::*;
#(
  parameter int CLK_CYC  = 10,
  parameter int TICK_CYC = tick_cyc_default(CLK_CYC),
  parameter int LONG_MS  = 1000,
  parameter int DBL_MS   = 250,
  parameter int CNT_W    = 12
) (
  input  logic sysclk,
  input  logic sysrst,
  input  logic key_level,
  output logic key_held,
  output logic short_press,
  output logic double_click,
  output logic long_press
);

  localparam logic [CNT_W-1:0] C_LONG_LAST = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] C_DBL_LAST  = CNT_W'(DBL_MS - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

  key_state_t       r_state;
  key_state_t       w_state_nxt;
  logic             r_key_d;
  logic [CNT_W-1:0] r_ms_cnt;
  logic             r_short;
  logic             r_dbl;
  logic             r_long;
  logic             w_short_nxt;
  logic             w_dbl_nxt;
  logic             w_long_nxt;
  logic             w_fall;
  logic             w_rise;
  logic             w_tick;
  logic             w_clr;

  // Edges are taken between the live level and its one-cycle-old copy, so a
  // key already held when reset drops is seen as a fresh press.
  assign w_fall = (key_level == KEY_PRESSED) && (r_key_d != KEY_PRESSED);
  assign w_rise = (key_level != KEY_PRESSED) && (r_key_d == KEY_PRESSED);

  // All timing restarts from the moment a new state is entered.
  assign w_clr = (w_state_nxt != r_state);

  ms_tick #(
    .TICK_CYC (TICK_CYC)
  ) u_ms_tick (
    .sysclk (sysclk),
    .sysrst (sysrst),
    .clr    (w_clr),
    .tick   (w_tick)
  );

  // Delayed key level used for edge detection and the held indication.
  always_ff @(posedge sysclk) begin
    if (sysrst) begin
      r_key_d <= 1'b1;
    end else begin
      r_key_d <= key_level;
    end
  end

  // Milliseconds spent in the current state, saturating at all-ones.
  always_ff @(posedge sysclk) begin
    if (sysrst || w_clr) begin
      r_ms_cnt <= '0;
    end else if (w_tick && (r_ms_cnt != C_CNT_MAX)) begin
      r_ms_cnt <= r_ms_cnt + C_CNT_ONE;
    end
  end

  // Next-state and event decode; edges take priority over timeouts.
  always_comb begin
    w_state_nxt = r_state;
    w_short_nxt = 1'b0;
    w_dbl_nxt   = 1'b0;
    w_long_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_nxt = PRESS1;
        end
      end
      PRESS1: begin
        if (w_rise) begin
          w_state_nxt = WAIT2;
        end else if (w_tick && (r_ms_cnt == C_LONG_LAST)) begin
          w_long_nxt  = 1'b1;
          w_state_nxt = WAIT_REL;
        end
      end
      WAIT2: begin
        if (w_fall) begin
          w_dbl_nxt   = 1'b1;
          w_state_nxt = WAIT_REL;
        end else if (w_tick && (r_ms_cnt == C_DBL_LAST)) begin
          w_short_nxt = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      WAIT_REL: begin
        if (w_rise) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register and registered one-cycle event pulses.
  always_ff @(posedge sysclk) begin
    if (sysrst) begin
      r_state <= IDLE;
      r_short <= 1'b0;
      r_dbl   <= 1'b0;
      r_long  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_short <= w_short_nxt;
      r_dbl   <= w_dbl_nxt;
      r_long  <= w_long_nxt;
    end
  end

  assign key_held     = ~r_key_d;
  assign short_press  = r_short;
  assign double_click = r_dbl;
  assign long_press   = r_long;

endmodule

`default_nettype wire

// File: tb/tb_key_event.sv
// ============================================================================
//  Module      : tb_key_event
//  Description : Self-checking bench for key_event with a 10-cycle ms tick,
//                20 ms long press and 5 ms double-click window.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_event;

  logic clk;
  logic rst;
  logic key;
  logic held;
  logic sp;
  logic dc;
  logic lp;

  int cyc;
  int n_chk;
  int n_fail;

  // Pulse log written only by the monitor.
  int tot_s;
  int tot_d;
  int tot_l;
  int tot_multi;
  int pulse_cyc[$];

  typedef struct {
    int l1;
    int gap;
    int l2;
    int exp_s;
    int exp_d;
    int exp_l;
    int exp_first;
  } vec_t;

  vec_t vecs[10];

  key_event #(
    .CLK_CYC  (10),
    .TICK_CYC (10),
    .LONG_MS  (20),
    .DBL_MS   (5),
    .CNT_W    (12)
  ) dut (
    .sysclk       (clk),
    .sysrst       (rst),
    .key_level    (key),
    .key_held     (held),
    .short_press  (sp),
    .double_click (dc),
    .long_press   (lp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index = number of rising edges seen so far.
  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Log every pulse with the cycle it is visible in.
  initial begin
    tot_s = 0; tot_d = 0; tot_l = 0; tot_multi = 0;
  end
  always @(negedge clk) begin
    if (sp) tot_s = tot_s + 1;
    if (dc) tot_d = tot_d + 1;
    if (lp) tot_l = tot_l + 1;
    if ((int'(sp) + int'(dc) + int'(lp)) > 1) tot_multi = tot_multi + 1;
    if (sp || dc || lp) pulse_cyc.push_back(cyc);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_chk = n_chk + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Checks event counts and the first pulse cycle relative to a start cycle.
  task automatic check_events(input string tag, input int s0, input int d0, input int l0,
                              input int m0, input int q0, input int a,
                              input int es, input int ed, input int el, input int efirst);
    int first;
    check({tag, " short count"}, tot_s - s0, es);
    check({tag, " double count"}, tot_d - d0, ed);
    check({tag, " long count"}, tot_l - l0, el);
    check({tag, " overlapping pulses"}, tot_multi - m0, 0);
    if (efirst >= 0) begin
      first = (pulse_cyc.size() > q0) ? (pulse_cyc[q0] - a) : -1;
      check({tag, " first pulse cycle"}, first, efirst);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int a, s0, d0, l0, m0, q0;
    s0 = tot_s; d0 = tot_d; l0 = tot_l; m0 = tot_multi; q0 = pulse_cyc.size();
    a = cyc;
    key = 1'b0;
    step(v.l1);
    key = 1'b1;
    if (v.l2 > 0) begin
      step(v.gap);
      key = 1'b0;
      step(v.l2);
      key = 1'b1;
    end
    step(150);
    check_events($sformatf("vec%0d", idx), s0, d0, l0, m0, q0, a,
                 v.exp_s, v.exp_d, v.exp_l, v.exp_first);
  endtask

  initial begin
    int a, s0, d0, l0, m0, q0;
    n_chk  = 0;
    n_fail = 0;

    // Offsets count rising edges from the cycle the first low is driven;
    // the live level is sampled one edge later.
    vecs[0] = '{50,  0,  0, 1, 0, 0, 101};  // short press
    vecs[1] = '{400, 0,  0, 0, 0, 1, 201};  // long press, silent release
    vecs[2] = '{30,  20, 30, 0, 1, 0, 51};  // double click
    vecs[3] = '{30,  49, 30, 0, 1, 0, 80};  // gap one short of the window
    vecs[4] = '{30,  50, 30, 0, 1, 0, 81};  // second press lands on timeout: fall wins
    vecs[5] = '{30,  51, 30, 2, 0, 0, 81};  // window expired, second press is fresh
    vecs[6] = '{200, 0,  0, 1, 0, 0, 251};  // release on long timeout: rise wins
    vecs[7] = '{201, 0,  0, 0, 0, 1, 201};  // held one cycle longer: long press
    vecs[8] = '{1,   0,  0, 1, 0, 0, 52};   // one-cycle press
    vecs[9] = '{30,  20, 400, 0, 1, 0, 51}; // double click then long hold

    rst = 1'b1;
    key = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset outputs", {28'd0, held, sp, dc, lp}, 0);
    end
    rst = 1'b0;
    step(5);

    for (int i = 0; i < 10; i++) begin
      run_vec(i, vecs[i]);
    end

    // key_held follows the level one cycle late.
    key = 1'b0;
    @(negedge clk);
    check("held before registered", int'(held), 0);
    step(1);
    @(negedge clk);
    check("held while pressed", int'(held), 1);

    // Reset mid-press, key kept low: a new press starts right after reset.
    s0 = tot_s; d0 = tot_d; l0 = tot_l; m0 = tot_multi; q0 = pulse_cyc.size();
    step(98);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      @(negedge clk);
      check("outputs in reset", {28'd0, held, sp, dc, lp}, 0);
    end
    rst = 1'b0;
    step(1);
    a = cyc - 104;
    step(250);
    check("held after reset", int'(held), 1);
    key = 1'b1;
    step(150);
    check_events("reset mid-press", s0, d0, l0, m0, q0, a, 0, 0, 1, 304);

    // Reset during the double-click window drops the pending short press.
    s0 = tot_s; d0 = tot_d; l0 = tot_l; m0 = tot_multi; q0 = pulse_cyc.size();
    a = cyc;
    key = 1'b0;
    step(20);
    key = 1'b1;
    step(10);
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(150);
    check_events("reset in window", s0, d0, l0, m0, q0, a, 0, 0, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
